// File: rtl/decode_stage.sv
// Decode stage of the five-stage pipeline.
// Owns the 8x16 register file with write-back bypass, decodes the fetch fields
// into control signals, detects load-use hazards and drives the ID/EX register.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [5:0]        if_opcode,
    input  logic [2:0]        if_src,
    input  logic [2:0]        if_dst,
    input  logic [3:0]        if_shamt,
    output logic              id_stall,
    input  logic              ex_ready,
    input  logic              ex_flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_valid,
    output logic [2:0]        id_aluop,
    output logic [DATA_W-1:0] id_src_val,
    output logic [DATA_W-1:0] id_dst_val,
    output logic [2:0]        id_dst,
    output logic [3:0]        id_shamt,
    output logic              id_mem_rd,
    output logic              id_mem_wr,
    output logic              id_reg_wr,
    output logic              id_illegal,
    output logic [CNT_W-1:0]  dec_count,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [5:0] {
        OP_ADD = 6'b000011,
        OP_NOT = 6'b000100,
        OP_NOP = 6'b000101,
        OP_LDD = 6'b010001,
        OP_STD = 6'b010010
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_PASS    = 3'd0,
        ALU_ADD     = 3'd1,
        ALU_NOT     = 3'd2,
        ALU_NOP     = 3'd3,
        ALU_ILLEGAL = 3'd7
    } aluop_e;

    // Contents of the ID/EX pipeline register; all-zero is a bubble.
    typedef struct packed {
        logic              valid;
        logic [2:0]        aluop;
        logic [DATA_W-1:0] src_val;
        logic [DATA_W-1:0] dst_val;
        logic [2:0]        dst;
        logic [3:0]        shamt;
        logic              mem_rd;
        logic              mem_wr;
        logic              reg_wr;
        logic              illegal;
    } idex_t;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] src_rd;
    logic [DATA_W-1:0] dst_rd;

    idex_t             idex_q, idex_d;
    idex_t             dec;
    logic              rd_src;
    logic              rd_dst;
    logic              hazard;
    logic [CNT_W-1:0]  dec_count_q, dec_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    // Register file next state: a single write port from write-back.
    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
        rf_d = rf_q;
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Operand reads; a same-cycle write-back to the addressed register wins.
    always_comb begin
        src_rd = rf_q[if_src];
        dst_rd = rf_q[if_dst];
        if (wb_en && (wb_addr == if_src)) begin
            src_rd = wb_data;
        end
        if (wb_en && (wb_addr == if_dst)) begin
            dst_rd = wb_data;
        end
    end

    // Decode the fetch fields into an ID/EX image and note which registers it reads.
    always_comb begin
        dec    = '0;
        rd_src = 1'b0;
        rd_dst = 1'b0;
        if (if_valid) begin
            dec.valid   = 1'b1;
            dec.src_val = src_rd;
            dec.dst_val = dst_rd;
            dec.dst     = if_dst;
            dec.shamt   = if_shamt;
            case (if_opcode)
                OP_ADD: begin
                    dec.aluop  = ALU_ADD;
                    dec.reg_wr = 1'b1;
                    rd_src     = 1'b1;
                    rd_dst     = 1'b1;
                end
                OP_NOT: begin
                    dec.aluop  = ALU_NOT;
                    dec.reg_wr = 1'b1;
                    rd_dst     = 1'b1;
                end
                OP_NOP: begin
                    dec.aluop = ALU_NOP;
                end
                OP_LDD: begin
                    dec.aluop  = ALU_PASS;
                    dec.mem_rd = 1'b1;
                    dec.reg_wr = 1'b1;
                end
                OP_STD: begin
                    dec.aluop  = ALU_PASS;
                    dec.mem_wr = 1'b1;
                    rd_src     = 1'b1;
                    rd_dst     = 1'b1;
                end
                default: begin
                    // Unknown opcode: a bubble that carries only the illegal flag.
                    dec         = '0;
                    dec.aluop   = ALU_ILLEGAL;
                    dec.illegal = 1'b1;
                end
            endcase
        end
    end

    // Load-use hazard: a valid ldd in ID/EX whose destination the incoming instruction reads.
    assign hazard = idex_q.valid && idex_q.mem_rd &&
                    ((rd_src && (if_src == idex_q.dst)) ||
                     (rd_dst && (if_dst == idex_q.dst)));

    // ID/EX update by priority flush > hold > hazard bubble > capture, plus the fetch stall.
    always_comb begin
        idex_d        = idex_q;
        dec_count_d   = dec_count_q;
        stall_count_d = stall_count_q;
        id_stall      = 1'b0;
        if (ex_flush) begin
            idex_d = '0;
        end else if (!ex_ready) begin
            id_stall = 1'b1;
        end else if (hazard) begin
            idex_d        = '0;
            id_stall      = 1'b1;
            stall_count_d = stall_count_q + CNT_W'(1);
        end else begin
            idex_d = dec;
            if (dec.valid) begin
                dec_count_d = dec_count_q + CNT_W'(1);
            end
        end
        // Reset drops any stall and the held instruction immediately.
        if (rst) begin
            id_stall = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            idex_q        <= '0;
            dec_count_q   <= '0;
            stall_count_q <= '0;
            // NOTE: the register file is architecturally cleared by reset, so this array is reset too.
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            idex_q        <= idex_d;
            dec_count_q   <= dec_count_d;
            stall_count_q <= stall_count_d;
            rf_q          <= rf_d;
        end
    end

    assign id_valid    = idex_q.valid;
    assign id_aluop    = idex_q.aluop;
    assign id_src_val  = idex_q.src_val;
    assign id_dst_val  = idex_q.dst_val;
    assign id_dst      = idex_q.dst;
    assign id_shamt    = idex_q.shamt;
    assign id_mem_rd   = idex_q.mem_rd;
    assign id_mem_wr   = idex_q.mem_wr;
    assign id_reg_wr   = idex_q.reg_wr;
    assign id_illegal  = idex_q.illegal;
    assign dec_count   = dec_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a vector table for single-cycle decode
// and register-file behaviour, then hand-written hazard/flush/hold/reset/wrap sequences.
`timescale 1ns/1ps
module tb_decode_stage;

    localparam logic [5:0] OP_ADD = 6'b000011;
    localparam logic [5:0] OP_NOT = 6'b000100;
    localparam logic [5:0] OP_NOP = 6'b000101;
    localparam logic [5:0] OP_LDD = 6'b010001;
    localparam logic [5:0] OP_STD = 6'b010010;
    localparam logic [5:0] OP_ILL = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [5:0]  op;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic [3:0]  shamt;
        logic        ready;
        logic        flush;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  aluop;
        logic [15:0] src_val;
        logic [15:0] dst_val;
        logic [2:0]  dst;
        logic [3:0]  shamt;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic        illegal;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
        logic  stall;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [5:0]  if_opcode;
    logic [2:0]  if_src;
    logic [2:0]  if_dst;
    logic [3:0]  if_shamt;
    logic        id_stall;
    logic        ex_ready;
    logic        ex_flush;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        id_valid;
    logic [2:0]  id_aluop;
    logic [15:0] id_src_val;
    logic [15:0] id_dst_val;
    logic [2:0]  id_dst;
    logic [3:0]  id_shamt;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic        id_reg_wr;
    logic        id_illegal;
    logic [15:0] dec_count;
    logic [15:0] stall_count;

    int    checks   = 0;
    int    failures = 0;
    exp_t  sb [$];
    string sb_name [$];
    vec_t  tbl [14];

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_opcode   (if_opcode),
        .if_src      (if_src),
        .if_dst      (if_dst),
        .if_shamt    (if_shamt),
        .id_stall    (id_stall),
        .ex_ready    (ex_ready),
        .ex_flush    (ex_flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .id_valid    (id_valid),
        .id_aluop    (id_aluop),
        .id_src_val  (id_src_val),
        .id_dst_val  (id_dst_val),
        .id_dst      (id_dst),
        .id_shamt    (id_shamt),
        .id_mem_rd   (id_mem_rd),
        .id_mem_wr   (id_mem_wr),
        .id_reg_wr   (id_reg_wr),
        .id_illegal  (id_illegal),
        .dec_count   (dec_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t st(input logic v, input logic [5:0] op, input logic [2:0] src,
                                 input logic [2:0] dst, input logic [3:0] sh);
        stim_t s;
        s       = '0;
        s.valid = v;
        s.op    = op;
        s.src   = src;
        s.dst   = dst;
        s.shamt = sh;
        s.ready = 1'b1;
        return s;
    endfunction

    function automatic stim_t wbw(input stim_t s, input logic [2:0] a, input logic [15:0] d);
        stim_t r;
        r         = s;
        r.wb_en   = 1'b1;
        r.wb_addr = a;
        r.wb_data = d;
        return r;
    endfunction

    function automatic exp_t ex(input logic v, input logic [2:0] alu, input logic [15:0] sv,
                                input logic [15:0] dv, input logic [2:0] dst, input logic [3:0] sh,
                                input logic rd, input logic wr, input logic rw, input logic ill);
        exp_t e;
        e.valid   = v;
        e.aluop   = alu;
        e.src_val = sv;
        e.dst_val = dv;
        e.dst     = dst;
        e.shamt   = sh;
        e.mem_rd  = rd;
        e.mem_wr  = wr;
        e.reg_wr  = rw;
        e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a.valid   = id_valid;
        a.aluop   = id_aluop;
        a.src_val = id_src_val;
        a.dst_val = id_dst_val;
        a.dst     = id_dst;
        a.shamt   = id_shamt;
        a.mem_rd  = id_mem_rd;
        a.mem_wr  = id_mem_wr;
        a.reg_wr  = id_reg_wr;
        a.illegal = id_illegal;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_out(input string name, input exp_t act, input exp_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got v=%b alu=%0d src=%h dst_val=%h dst=%0d sh=%0d rd=%b wr=%b rw=%b ill=%b expected v=%b alu=%0d src=%h dst_val=%h dst=%0d sh=%0d rd=%b wr=%b rw=%b ill=%b",
                     name, act.valid, act.aluop, act.src_val, act.dst_val, act.dst, act.shamt,
                     act.mem_rd, act.mem_wr, act.reg_wr, act.illegal,
                     req.valid, req.aluop, req.src_val, req.dst_val, req.dst, req.shamt,
                     req.mem_rd, req.mem_wr, req.reg_wr, req.illegal);
        end
    endtask

    task automatic drive(input stim_t s);
        rst       = s.rst;
        if_valid  = s.valid;
        if_opcode = s.op;
        if_src    = s.src;
        if_dst    = s.dst;
        if_shamt  = s.shamt;
        ex_ready  = s.ready;
        ex_flush  = s.flush;
        wb_en     = s.wb_en;
        wb_addr   = s.wb_addr;
        wb_data   = s.wb_data;
    endtask

    // Drive one cycle of stimulus, check the combinational stall, queue the expected
    // ID/EX image, then after the edge pop and compare it.
    task automatic apply(input stim_t s, input exp_t e, input logic exp_stall, input string name);
        exp_t  req;
        string nm;
        drive(s);
        #1;
        check({name, " stall"}, 32'(id_stall), 32'(exp_stall));
        sb.push_back(e);
        sb_name.push_back(name);
        @(posedge clk);
        #1;
        req = sb.pop_front();
        nm  = sb_name.pop_front();
        check_out(nm, dut_out(), req);
    endtask

    initial begin
        stim_t s;
        exp_t  bub;
        exp_t  held;
        bub = '0;

        // Table: register file clear, write-back, decode of each opcode, bypass, illegal.
        tbl[0]  = '{st(1, OP_NOP, 0, 1, 0),  ex(1, 3, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0), 1'b0};
        tbl[1]  = '{st(1, OP_NOP, 2, 3, 0),  ex(1, 3, 16'h0000, 16'h0000, 3, 0, 0, 0, 0, 0), 1'b0};
        tbl[2]  = '{st(1, OP_NOP, 4, 5, 0),  ex(1, 3, 16'h0000, 16'h0000, 5, 0, 0, 0, 0, 0), 1'b0};
        tbl[3]  = '{st(1, OP_NOP, 6, 7, 15), ex(1, 3, 16'h0000, 16'h0000, 7, 15, 0, 0, 0, 0), 1'b0};
        tbl[4]  = '{wbw(st(0, OP_NOP, 0, 0, 0), 1, 16'd5), bub, 1'b0};
        tbl[5]  = '{wbw(st(0, OP_NOP, 0, 0, 0), 2, 16'd3), bub, 1'b0};
        tbl[6]  = '{st(1, OP_ADD, 2, 1, 9),  ex(1, 1, 16'd3, 16'd5, 1, 9, 0, 0, 1, 0), 1'b0};
        tbl[7]  = '{wbw(st(1, OP_NOT, 0, 3, 0), 3, 16'hABCD),
                    ex(1, 2, 16'h0000, 16'hABCD, 3, 0, 0, 0, 1, 0), 1'b0};
        tbl[8]  = '{st(1, OP_STD, 1, 2, 4),  ex(1, 0, 16'd5, 16'd3, 2, 4, 0, 1, 0, 0), 1'b0};
        tbl[9]  = '{st(1, OP_LDD, 2, 5, 0),  ex(1, 0, 16'd3, 16'd0, 5, 0, 1, 0, 1, 0), 1'b0};
        // not only reads dst, so a src match against the pending ldd is not a hazard
        tbl[10] = '{st(1, OP_NOT, 5, 1, 0),  ex(1, 2, 16'd0, 16'd5, 1, 0, 0, 0, 1, 0), 1'b0};
        tbl[11] = '{st(1, OP_ILL, 1, 2, 3),  ex(0, 7, 16'd0, 16'd0, 0, 0, 0, 0, 0, 1), 1'b0};
        tbl[12] = '{st(1, OP_LDD, 1, 6, 0),  ex(1, 0, 16'd5, 16'd0, 6, 0, 1, 0, 1, 0), 1'b0};
        // an invalid slot never raises a hazard, even with matching fields
        tbl[13] = '{st(0, OP_ADD, 6, 6, 0),  bub, 1'b0};

        // Reset for two cycles with a valid instruction presented.
        s     = st(1, OP_ADD, 1, 2, 0);
        s.rst = 1'b1;
        apply(s, bub, 1'b0, "reset0");
        apply(s, bub, 1'b0, "reset1");
        check("reset dec_count", 32'(dec_count), 32'd0);
        check("reset stall_count", 32'(stall_count), 32'd0);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].s, tbl[i].e, tbl[i].stall, $sformatf("vec%0d", i));
            if (i == 11) begin
                check("illegal keeps dec_count", 32'(dec_count), 32'd9);
            end
        end
        check("table dec_count", 32'(dec_count), 32'd10);
        check("table stall_count", 32'(stall_count), 32'd0);

        // Hazard on add src: r1=5 r2=3 r3=ABCD.
        apply(st(1, OP_LDD, 0, 1, 0), ex(1, 0, 16'd0, 16'd5, 1, 0, 1, 0, 1, 0), 1'b0, "h1 ldd");
        apply(st(1, OP_ADD, 1, 2, 0), bub, 1'b1, "h1 bubble");
        check("h1 stall_count", 32'(stall_count), 32'd1);
        apply(st(1, OP_ADD, 1, 2, 0), ex(1, 1, 16'd5, 16'd3, 2, 0, 0, 0, 1, 0), 1'b0, "h1 add");

        // Hazard on std dst.
        apply(st(1, OP_LDD, 0, 4, 0), ex(1, 0, 16'd0, 16'd0, 4, 0, 1, 0, 1, 0), 1'b0, "h2 ldd");
        apply(st(1, OP_STD, 0, 4, 0), bub, 1'b1, "h2 bubble");
        apply(st(1, OP_STD, 0, 4, 0), ex(1, 0, 16'd0, 16'd0, 4, 0, 0, 1, 0, 0), 1'b0, "h2 std");

        // Hazard on not dst.
        apply(st(1, OP_LDD, 0, 3, 0), ex(1, 0, 16'd0, 16'hABCD, 3, 0, 1, 0, 1, 0), 1'b0, "h3 ldd");
        apply(st(1, OP_NOT, 0, 3, 0), bub, 1'b1, "h3 bubble");
        apply(st(1, OP_NOT, 0, 3, 0), ex(1, 2, 16'd0, 16'hABCD, 3, 0, 0, 0, 1, 0), 1'b0, "h3 not");
        check("h3 stall_count", 32'(stall_count), 32'd3);

        // Flush during a hazard cycle: bubble, no stall, no hazard count.
        apply(st(1, OP_LDD, 0, 1, 0), ex(1, 0, 16'd0, 16'd5, 1, 0, 1, 0, 1, 0), 1'b0, "fl ldd");
        s       = st(1, OP_ADD, 1, 2, 0);
        s.flush = 1'b1;
        apply(s, bub, 1'b0, "fl bubble");
        check("fl stall_count", 32'(stall_count), 32'd3);
        held = ex(1, 1, 16'd5, 16'd3, 2, 0, 0, 0, 1, 0);
        apply(st(1, OP_ADD, 1, 2, 0), held, 1'b0, "fl add");
        check("fl dec_count", 32'(dec_count), 32'd18);

        // EX not ready for three cycles: ID/EX holds, fetch stalls.
        s       = st(1, OP_NOT, 0, 1, 0);
        s.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(s, held, 1'b1, $sformatf("hold%0d", i));
        end
        check("hold dec_count", 32'(dec_count), 32'd18);
        apply(st(1, OP_NOT, 0, 1, 0), ex(1, 2, 16'd0, 16'd5, 1, 0, 0, 0, 1, 0), 1'b0, "hold release");

        // Not-ready outranks the hazard: hold without counting, then bubble, then capture.
        held = ex(1, 0, 16'd0, 16'd0, 7, 0, 1, 0, 1, 0);
        apply(st(1, OP_LDD, 0, 7, 0), held, 1'b0, "hh ldd");
        s       = st(1, OP_ADD, 7, 0, 0);
        s.ready = 1'b0;
        apply(s, held, 1'b1, "hh hold");
        check("hh hold stall_count", 32'(stall_count), 32'd3);
        apply(st(1, OP_ADD, 7, 0, 0), bub, 1'b1, "hh bubble");
        check("hh stall_count", 32'(stall_count), 32'd4);
        apply(st(1, OP_ADD, 7, 0, 0), ex(1, 1, 16'd0, 16'd0, 0, 0, 0, 0, 1, 0), 1'b0, "hh add");

        // Flush without a hazard discards a valid capture.
        s       = st(1, OP_NOP, 1, 2, 0);
        s.flush = 1'b1;
        apply(s, bub, 1'b0, "flush nop");
        check("flush dec_count", 32'(dec_count), 32'd21);

        // Reset asserted during a stall cycle.
        apply(st(1, OP_LDD, 0, 1, 0), ex(1, 0, 16'd0, 16'd5, 1, 0, 1, 0, 1, 0), 1'b0, "rs ldd");
        s     = st(1, OP_ADD, 1, 2, 0);
        s.rst = 1'b1;
        apply(s, bub, 1'b0, "rs reset");
        check("rs dec_count", 32'(dec_count), 32'd0);
        check("rs stall_count", 32'(stall_count), 32'd0);
        apply(st(1, OP_NOP, 1, 3, 0), ex(1, 3, 16'd0, 16'd0, 3, 0, 0, 0, 0, 0), 1'b0, "rs regs cleared");
        apply(st(1, OP_NOP, 2, 0, 0), ex(1, 3, 16'd0, 16'd0, 0, 0, 0, 0, 0, 0), 1'b0, "rs regs cleared2");

        // dec_count wrap: 2 so far, 65533 more reaches 0xFFFF, then 0, then 1.
        drive(st(1, OP_NOP, 0, 0, 0));
        for (int i = 0; i < 65533; i++) begin
            @(posedge clk);
        end
        #1;
        check("wrap max", 32'(dec_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        check("wrap zero", 32'(dec_count), 32'd0);
        @(posedge clk);
        #1;
        check("wrap one", 32'(dec_count), 32'd1);
        check("wrap stall_count", 32'(stall_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
